// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with blanking gaps and a
// double-buffered display value. Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  output logic        wr_ready,
  input  logic [3:0]  digit_en,
  output logic [3:0]  AN,
  output logic [6:0]  seg,
  output logic        seg_P,
  output logic        frame_tick
);

  localparam int unsigned MaxCycles = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(DIGIT_CYCLES - 1);

  typedef enum logic {StBlank, StDrive} state_e;

  state_e          r_state, w_state_d;
  logic [1:0]      r_digit, w_digit_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;

  logic [15:0] r_active, r_shadow;
  logic [3:0]  r_active_dp, r_shadow_dp;
  logic        r_pending, r_wr_ready, r_frame_tick;
  logic [3:0]  r_an, w_an_d;
  logic [6:0]  r_seg, w_seg_d;
  logic        r_seg_p, w_seg_p_d;

  logic        w_boundary, w_accept, w_show, w_dp_bit;
  logic [15:0] w_shifted;
  logic [3:0]  w_nib;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_boundary = (r_state == StDrive) && (r_digit == 2'd3) && (r_cnt == DriveLast);
  assign w_accept   = wr_en & r_wr_ready;

  always_comb begin
    w_state_d = r_state;
    w_digit_d = r_digit;
    w_cnt_d   = r_cnt + 1'b1;
    unique case (r_state)
      StBlank: if (r_cnt == BlankLast) begin
        w_state_d = StDrive;
        w_cnt_d   = '0;
      end
      StDrive: if (r_cnt == DriveLast) begin
        w_state_d = StBlank;
        w_digit_d = r_digit + 2'd1;
        w_cnt_d   = '0;
      end
      default: w_state_d = StBlank;
    endcase
  end

  // Outputs are registered, so decode for the slot being entered, not the current one.
  assign w_shifted = r_active >> {w_digit_d, 2'b00};
  assign w_nib     = w_shifted[3:0];
  assign w_dp_bit  = r_active_dp[w_digit_d];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign w_show = digit_en[w_digit_d] & ((w_digit_d == 2'd0) | (w_shifted != 16'h0) | w_dp_bit);
`else
  assign w_show = digit_en[w_digit_d];
`endif

  always_comb begin
    w_an_d    = 4'hF;
    w_seg_d   = 7'h7F;
    w_seg_p_d = 1'b1;
    if (w_state_d == StDrive) begin
      if (w_show) w_an_d = ~(4'b0001 << w_digit_d);
      w_seg_d   = hex_to_seg(w_nib);
      w_seg_p_d = ~w_dp_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StBlank;
      r_digit      <= 2'd0;
      r_cnt        <= '0;
      r_active     <= 16'h0;
      r_active_dp  <= 4'h0;
      r_shadow     <= 16'h0;
      r_shadow_dp  <= 4'h0;
      r_pending    <= 1'b0;
      r_wr_ready   <= 1'b1;
      r_frame_tick <= 1'b0;
      r_an         <= 4'hF;
      r_seg        <= 7'h7F;
      r_seg_p      <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_digit      <= w_digit_d;
      r_cnt        <= w_cnt_d;
      r_an         <= w_an_d;
      r_seg        <= w_seg_d;
      r_seg_p      <= w_seg_p_d;
      r_frame_tick <= w_boundary;
      r_wr_ready   <= ~r_pending;
      if (w_boundary && r_pending) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
      end
      // A write on the boundary cycle lands in the shadow and waits a full frame.
      if (w_accept) begin
        r_shadow    <= wr_data;
        r_shadow_dp <= wr_dp;
        r_pending   <= 1'b1;
      end else if (w_boundary) begin
        r_pending   <= 1'b0;
      end
    end
  end

  assign wr_ready   = r_wr_ready;
  assign frame_tick = r_frame_tick;
  assign AN         = r_an;
  assign seg        = r_seg;
  assign seg_P      = r_seg_p;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2 (frame = 40 clocks).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic [3:0]  wr_dp = 4'h0;
  logic        wr_ready;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  AN;
  logic [6:0]  seg;
  logic        seg_P;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
    .wr_ready(wr_ready), .digit_en(digit_en), .AN(AN), .seg(seg), .seg_P(seg_P),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  // Steps to cycle 'to', checking every sample against the expected scan pattern.
  task automatic run_chk(input int to, input logic [15:0] val, input logic [3:0] dp,
                         input logic [3:0] en);
    int k, s, ph;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_p;
    logic        show;
    logic [15:0] up;
    while (cyc < to) begin
      tick();
      k  = cyc % 40;
      s  = k / 10;
      ph = k % 10;
      if (ph < 2) begin
        e_an = 4'hF; e_seg = 7'h7F; e_p = 1'b1;
      end else begin
        up   = val >> (4 * s);
        show = en[s];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (s != 0 && up == 16'h0 && !dp[s]) show = 1'b0;
`endif
        e_an  = show ? ~(4'b0001 << s) : 4'hF;
        e_seg = hex7[up[3:0]];
        e_p   = ~dp[s];
      end
      chk("an", 32'(AN), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("seg_p", 32'(seg_P), 32'(e_p));
      chk("frame_tick", 32'(frame_tick), 32'(k == 0));
      chk("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
    end
  endtask

  initial begin
    logic [3:0] e_an39;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_seg_p", 32'(seg_P), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_frame_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // First write, accepted on edge 1; frame 0 still shows zeros.
    wr_en = 1'b1; wr_data = 16'h1A3F; wr_dp = 4'b0100;
    tick();
    wr_en = 1'b0;
    chk("w1_ready_c1", 32'(wr_ready), 32'd1);
    chk("blank_c1", 32'(AN), 32'hF);
    tick();
    chk("w1_ready_c2", 32'(wr_ready), 32'd0);
    chk("d0_an_c2", 32'(AN), 32'hE);
    chk("d0_seg_c2", 32'(seg), 32'h40);
    chk("d0_segp_c2", 32'(seg_P), 32'd1);
    tick_to(39);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    e_an39 = 4'hF;
`else
    e_an39 = 4'h7;
`endif
    chk("d3_an_c39", 32'(AN), 32'(e_an39));
    chk("tick_c39", 32'(frame_tick), 32'd0);
    chk("ready_c39", 32'(wr_ready), 32'd0);
    tick();
    chk("tick_c40", 32'(frame_tick), 32'd1);
    chk("ready_c40", 32'(wr_ready), 32'd0);
    tick();
    chk("tick_c41", 32'(frame_tick), 32'd0);
    chk("ready_c41", 32'(wr_ready), 32'd1);
    run_chk(80, 16'h1A3F, 4'b0100, 4'hF);

    // Two writes in one frame: second one arrives while wr_ready is low.
    wr_en = 1'b1; wr_data = 16'h1111; wr_dp = 4'b0000;
    tick();
    wr_en = 1'b0;
    tick();
    chk("ready_c82", 32'(wr_ready), 32'd0);
    tick_to(84);
    wr_en = 1'b1; wr_data = 16'h2222;
    tick(); tick();
    wr_en = 1'b0;
    run_chk(120, 16'h1A3F, 4'b0100, 4'hF);
    chk("ready_c120", 32'(wr_ready), 32'd0);
    tick();
    chk("ready_c121", 32'(wr_ready), 32'd1);
    run_chk(160 - 1, 16'h1111, 4'b0000, 4'hF);

    // Write accepted on the frame-boundary edge waits one more frame.
    wr_en = 1'b1; wr_data = 16'h5C0E; wr_dp = 4'b0001;
    tick();
    wr_en = 1'b0;
    chk("bnd_ready_c160", 32'(wr_ready), 32'd1);
    chk("bnd_tick_c160", 32'(frame_tick), 32'd1);
    tick();
    chk("bnd_ready_c161", 32'(wr_ready), 32'd0);
    run_chk(200, 16'h1111, 4'b0000, 4'hF);
    run_chk(240, 16'h5C0E, 4'b0001, 4'hF);

    digit_en = 4'b1011;
    run_chk(280, 16'h5C0E, 4'b0001, 4'b1011);
    digit_en = 4'hF;
    tick();
    run_chk(400, 16'h5C0E, 4'b0001, 4'hF);

    // Pending write, then asynchronous reset during digit 2 drive.
    tick();
    wr_en = 1'b1; wr_data = 16'h9999; wr_dp = 4'hF;
    tick();
    wr_en = 1'b0;
    tick_to(425);
    chk("pre_rst_an", 32'(AN), 32'hB);
    chk("pre_rst_ready", 32'(wr_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(AN), 32'hF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_segp", 32'(seg_P), 32'd1);
    chk("async_rst_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    run_chk(40, 16'h0000, 4'h0, 4'hF);

    wr_en = 1'b1; wr_data = 16'h0070; wr_dp = 4'h0;
    tick();
    wr_en = 1'b0;
    run_chk(80, 16'h0000, 4'h0, 4'hF);
    run_chk(120, 16'h0070, 4'h0, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
